// File: rtl/div_32bit_seq.sv
// div_32bit_seq: signed 32-bit restoring divider, one quotient bit per clock.
// Magnitudes are divided, then quotient and remainder are sign-corrected.
// Quotient -> Rz_lo, remainder -> Rz_hi (truncating division).
// Optional macro DIV_BY_ZERO_FLAG_EN: adds the dbz port and a one-cycle
// short path for Rb == 0 (Rz_lo = 0, Rz_hi = Ra).
module div_32bit_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] Ra,
  input  logic [31:0] Rb,
  output logic        busy,
  output logic        done,
  output logic [31:0] Rz_lo,
  output logic [31:0] Rz_hi
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic        dbz
`endif
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state_reg, state_next;
  logic [31:0] dvd_reg, dvd_next;   // dividend magnitude, becomes the quotient
  logic [31:0] dvs_reg, dvs_next;   // divisor magnitude
  logic [31:0] rem_reg, rem_next;   // partial remainder (always < divisor)
  logic [4:0]  cnt_reg, cnt_next;
  logic        sign_q_reg, sign_q_next;
  logic        sign_r_reg, sign_r_next;
  logic [31:0] lo_next, hi_next;
  logic        done_next;
  logic [32:0] rem_sh;              // shifted remainder, compared at 33 bits
`ifdef DIV_BY_ZERO_FLAG_EN
  logic        zero_reg, zero_next;
  logic        dbz_next;
`endif

  // Same invert-plus-one negation as the datapath negate stage.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  assign busy = (state_reg == ITER) || (state_reg == FIX);

  // State register; clear forces IDLE at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic, datapath step and result formation.
  always_comb begin
    state_next  = state_reg;
    dvd_next    = dvd_reg;
    dvs_next    = dvs_reg;
    rem_next    = rem_reg;
    cnt_next    = cnt_reg;
    sign_q_next = sign_q_reg;
    sign_r_next = sign_r_reg;
    lo_next     = Rz_lo;
    hi_next     = Rz_hi;
    done_next   = 1'b0;
    rem_sh      = {rem_reg, dvd_reg[31]};
`ifdef DIV_BY_ZERO_FLAG_EN
    zero_next   = zero_reg;
    dbz_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          dvd_next    = Ra[31] ? neg32(Ra) : Ra;
          dvs_next    = Rb[31] ? neg32(Rb) : Rb;
          sign_q_next = Ra[31] ^ Rb[31];
          sign_r_next = Ra[31];
          rem_next    = 32'd0;
          cnt_next    = 5'd0;
          state_next  = ITER;
`ifdef DIV_BY_ZERO_FLAG_EN
          zero_next   = (Rb == 32'd0);
          if (Rb == 32'd0) state_next = FIX;
`endif
        end
      end
      ITER: begin
        // Restoring step: the difference fits in 32 bits whenever it is taken.
        if (rem_sh >= {1'b0, dvs_reg}) begin
          rem_next = rem_sh[31:0] - dvs_reg;
          dvd_next = {dvd_reg[30:0], 1'b1};
        end else begin
          rem_next = rem_sh[31:0];
          dvd_next = {dvd_reg[30:0], 1'b0};
        end
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) state_next = FIX;
      end
      FIX: begin
        done_next  = 1'b1;
        lo_next    = sign_q_reg ? neg32(dvd_reg) : dvd_reg;
        hi_next    = sign_r_reg ? neg32(rem_reg) : rem_reg;
        state_next = IDLE;
`ifdef DIV_BY_ZERO_FLAG_EN
        // dvd_reg still holds |Ra| because the iterations were skipped.
        if (zero_reg) begin
          dbz_next = 1'b1;
          lo_next  = 32'd0;
          hi_next  = sign_r_reg ? neg32(dvd_reg) : dvd_reg;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers; all cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      dvd_reg    <= 32'd0;
      dvs_reg    <= 32'd0;
      rem_reg    <= 32'd0;
      cnt_reg    <= 5'd0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      Rz_lo      <= 32'd0;
      Rz_hi      <= 32'd0;
      done       <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
      zero_reg   <= 1'b0;
      dbz        <= 1'b0;
`endif
    end else begin
      dvd_reg    <= dvd_next;
      dvs_reg    <= dvs_next;
      rem_reg    <= rem_next;
      cnt_reg    <= cnt_next;
      sign_q_reg <= sign_q_next;
      sign_r_reg <= sign_r_next;
      Rz_lo      <= lo_next;
      Rz_hi      <= hi_next;
      done       <= done_next;
`ifdef DIV_BY_ZERO_FLAG_EN
      zero_reg   <= zero_next;
      dbz        <= dbz_next;
`endif
    end
  end

endmodule

// File: tb/tb_div_32bit_seq.sv
// tb_div_32bit_seq: self-checking bench for div_32bit_seq.
// Honours DIV_BY_ZERO_FLAG_EN the same way as the design.
module tb_div_32bit_seq;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic        busy;
  logic        done;
  logic [31:0] Rz_lo;
  logic [31:0] Rz_hi;
  logic        dbz_w;

  int checks = 0;
  int failures = 0;

  div_32bit_seq dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .Ra    (Ra),
    .Rb    (Rb),
    .busy  (busy),
    .done  (done),
    .Rz_lo (Rz_lo),
    .Rz_hi (Rz_hi)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .dbz   (dbz_w)
`endif
  );

`ifndef DIV_BY_ZERO_FLAG_EN
  assign dbz_w = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: truncating signed division in 64-bit arithmetic, returns {rem, quo}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) begin
`ifdef DIV_BY_ZERO_FLAG_EN
      return {a, 32'd0};
`else
      // All-ones quotient magnitude, remainder |a|, then sign correction.
      return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
`endif
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_BY_ZERO_FLAG_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Starts one division and waits (bounded) for done; lat counts edges after the sampling edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] lo, output logic [31:0] hi, output logic z);
    @(negedge clock);
    Ra = a; Rb = b; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; Ra = $urandom; Rb = $urandom;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    lo = Rz_lo; hi = Rz_hi; z = dbz_w;
    $display("div Ra=%08h Rb=%08h -> lo=%08h hi=%08h lat=%0d", a, b, lo, hi, lat);
  endtask

  task automatic test_reset;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (dbz_w !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b want=0", dbz_w); end
    checks++; if (Rz_lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%08h want=0", Rz_lo); end
    checks++; if (Rz_hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%08h want=0", Rz_hi); end
    clear = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [31:0] lo, hi;
    logic z;
    do_div(32'd100, 32'd7, lat, bc, lo, hi, z);
    checks++; if (lat != 33) begin failures++; $display("FAIL basic_latency got=%0d want=33", lat); end
    checks++; if (bc != 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=33", bc); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL basic_lo got=%08h want=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL basic_hi got=%08h want=00000002", hi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", done); end
    repeat (3) @(negedge clock);
    checks++; if (Rz_lo !== 32'd14 || Rz_hi !== 32'd2) begin
      failures++; $display("FAIL basic_hold got=%08h/%08h want=0000000e/00000002", Rz_lo, Rz_hi);
    end
  endtask

  task automatic test_signs;
    logic [31:0] ta [5] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000, 32'd5};
    logic [31:0] tb [5] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd9};
    logic [31:0] el [5] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'h80000000, 32'd0};
    logic [31:0] eh [5] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd5};
    int lat, bc;
    logic [31:0] lo, hi;
    logic z;
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], lat, bc, lo, hi, z);
      checks++; if (lo !== el[i]) begin failures++; $display("FAIL sign_lo[%0d] got=%08h want=%08h", i, lo, el[i]); end
      checks++; if (hi !== eh[i]) begin failures++; $display("FAIL sign_hi[%0d] got=%08h want=%08h", i, hi, eh[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL sign_lat[%0d] got=%0d want=33", i, lat); end
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [31:0] lo, hi, a, b;
    logic [63:0] e;
    logic z;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 3)
        0: b = $urandom_range(1, 40);
        1: b = -$urandom_range(1, 40000);
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd3;
      if (i % 4 == 0) a = a >> $urandom_range(0, 31);
      e = ref_div(a, b);
      do_div(a, b, lat, bc, lo, hi, z);
      checks++; if (lo !== e[31:0] || hi !== e[63:32] || lat != 33) begin
        failures++;
        $display("FAIL random[%0d] Ra=%08h Rb=%08h got=%08h/%08h lat=%0d want=%08h/%08h lat=33",
                 i, a, b, lo, hi, lat, e[31:0], e[63:32]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clock);
    Ra = 32'd1000; Rb = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        Ra = $urandom; Rb = $urandom | 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    $display("ignore-start div 1000/3 -> lo=%08h hi=%08h lat=%0d", Rz_lo, Rz_hi, lat);
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_lat got=%0d want=33", lat); end
    checks++; if (Rz_lo !== 32'd333 || Rz_hi !== 32'd1) begin
      failures++; $display("FAIL ignore_result got=%08h/%08h want=0000014d/00000001", Rz_lo, Rz_hi);
    end
    lat = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) lat++;
    end
    checks++; if (lat != 0) begin failures++; $display("FAIL ignore_no_second_op got=%0d active cycles want=0", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [31:0] lo, hi;
    logic [63:0] e;
    logic z;
    do_div(32'hFFFFFFCE, 32'd7, lat, bc, lo, hi, z);
    checks++; if (lo !== 32'hFFFFFFF9 || hi !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL b2b_first got=%08h/%08h want=fffffff9/ffffffff", lo, hi);
    end
    // Still in the done cycle: request the next division right away.
    Ra = 32'd123456; Rb = 32'hFFFFFC18; start = 1'b1;
    e = ref_div(32'd123456, 32'hFFFFFC18);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    $display("b2b div 123456/-1000 -> lo=%08h hi=%08h lat=%0d", Rz_lo, Rz_hi, lat);
    checks++; if (lat != 33) begin failures++; $display("FAIL b2b_lat got=%0d want=33", lat); end
    checks++; if (Rz_lo !== e[31:0] || Rz_hi !== e[63:32]) begin
      failures++; $display("FAIL b2b_second got=%08h/%08h want=%08h/%08h", Rz_lo, Rz_hi, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_abort;
    int lat, bc, seen;
    logic [31:0] lo, hi;
    logic [63:0] e;
    logic z;
    @(negedge clock);
    Ra = 32'd99999; Rb = 32'd13; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (16) @(negedge clock);
    clear = 1'b0;
    #1;
    $display("abort at iteration 16 -> busy=%b done=%b lo=%08h hi=%08h", busy, done, Rz_lo, Rz_hi);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dbz_w !== 1'b0) begin
      failures++; $display("FAIL abort_flags got busy=%b done=%b dbz=%b want=0/0/0", busy, done, dbz_w);
    end
    checks++; if (Rz_lo !== 32'd0 || Rz_hi !== 32'd0) begin
      failures++; $display("FAIL abort_outputs got=%08h/%08h want=0/0", Rz_lo, Rz_hi);
    end
    @(negedge clock);
    clear = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
    e = ref_div(32'hFFFF0001, 32'd255);
    do_div(32'hFFFF0001, 32'd255, lat, bc, lo, hi, z);
    checks++; if (lo !== e[31:0] || hi !== e[63:32] || lat != 33) begin
      failures++; $display("FAIL abort_restart got=%08h/%08h lat=%0d want=%08h/%08h lat=33", lo, hi, lat, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] ta [2] = '{32'd7, 32'hFFFFFFF9};
    int lat, bc, el;
    logic [31:0] lo, hi;
    logic [63:0] e;
    logic z, ez;
`ifdef DIV_BY_ZERO_FLAG_EN
    ez = 1'b1;
`else
    ez = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      e  = ref_div(ta[i], 32'd0);
      el = exp_lat(32'd0);
      do_div(ta[i], 32'd0, lat, bc, lo, hi, z);
      checks++; if (lat != el) begin failures++; $display("FAIL dbz_lat[%0d] got=%0d want=%0d", i, lat, el); end
      checks++; if (bc != el) begin failures++; $display("FAIL dbz_busy[%0d] got=%0d want=%0d", i, bc, el); end
      checks++; if (lo !== e[31:0] || hi !== e[63:32]) begin
        failures++; $display("FAIL dbz_result[%0d] got=%08h/%08h want=%08h/%08h", i, lo, hi, e[31:0], e[63:32]);
      end
      checks++; if (z !== ez) begin failures++; $display("FAIL dbz_flag[%0d] got=%b want=%b", i, z, ez); end
      @(negedge clock);
      checks++; if (dbz_w !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL dbz_clear[%0d] got dbz=%b done=%b want=0/0", i, dbz_w, done);
      end
    end
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; Ra = 32'd0; Rb = 32'd0;
    test_reset;
    test_basic;
    test_signs;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    test_div_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
